matrix_multiplier_v3: RTL

Parametrised signed fixed-point matrix multiplier computing Z[M×N] = X[M×K] · Y[K×N] from row-major block RAMs, for the DFR output/readout layer.
It succeeds the v2 multiplier with the following changes:
- one read pair issued per cycle through a pipelined MAC;
- configurable RAM read latency;
- signed Q-format scaling;
- a start/busy/done handshake.
It sits between the reservoir/weight RAMs and the result RAM, and is started by the AXI control registers.

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/matmul_mac_unit.sv | 117 +++++++++++
 rtl/matrix_multiplier_v3.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix multiplier: FSM state encoding,
// saturation limits and the supported RAM read-latency range.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  // Largest value representable in a signed element of width dw.
  function automatic logic signed [63:0] SAT_MAX(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed element of width dw.
  function automatic logic signed [63:0] SAT_MIN(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Datapath of the matrix multiplier: read-valid delay line, signed
// multiply-accumulate and the Q-format output stage.
// Optional macro MATMUL_SATURATE_EN: clamp results and flag overflow;
// otherwise results wrap to DATA_WIDTH bits and overflow stays 0.
module matmul_mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int FRAC_BITS  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_clr_i,
  input  logic                         issue_i,
  input  logic                         acc_clr_i,
  input  logic                         load_i,
  input  logic signed [DATA_WIDTH-1:0] x_data_i,
  input  logic signed [DATA_WIDTH-1:0] y_data_i,
  output logic        [DATA_WIDTH-1:0] z_data_o,
  output logic                         overflow_o,
  output logic                         drain_last_o
);

  logic        [RD_LATENCY-1:0]   vld_q, vld_d;
  logic        [RD_LATENCY-1:0]   pend;
  logic                           mac_en;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d, acc_sum;
  logic        [DATA_WIDTH-1:0]   z_q, z_d;

  // Delay line tracks which issued reads return data this cycle; the final
  // stage marks a valid x_data/y_data pair. drain_last is high when the
  // only outstanding read is the one being consumed now.
  always_comb begin
    vld_d        = (vld_q << 1) | RD_LATENCY'(issue_i);
    mac_en       = vld_q[RD_LATENCY-1];
    pend         = vld_q << 1;
    drain_last_o = (pend == '0);
  end

  // Full-width signed product, sign-extended and accumulated with wrap.
  always_comb begin
    prod     = x_data_i * y_data_i;
    prod_ext = ACC_WIDTH'(prod);
    acc_sum  = mac_en ? acc_q + prod_ext : acc_q;
    acc_d    = (start_clr_i || acc_clr_i) ? '0 : acc_sum;
  end

`ifdef MATMUL_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(SAT_MAX(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(SAT_MIN(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] shifted;
  logic                        clamp;
  logic                        ovf_q, ovf_d;

  // Scale the final sum and clamp it into the element range.
  always_comb begin
    shifted = acc_sum >>> FRAC_BITS;
    clamp   = 1'b0;
    z_d     = z_q;
    if (load_i) begin
      z_d = shifted[DATA_WIDTH-1:0];
      if (shifted > SAT_HI) begin
        z_d   = SAT_HI[DATA_WIDTH-1:0];
        clamp = 1'b1;
      end else if (shifted < SAT_LO) begin
        z_d   = SAT_LO[DATA_WIDTH-1:0];
        clamp = 1'b1;
      end
    end
    ovf_d = ovf_q;
    if (start_clr_i) begin
      ovf_d = 1'b0;
    end else if (clamp) begin
      ovf_d = 1'b1;
    end
  end

  // Sticky overflow flag, cleared only by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  // Scale the final sum and keep its low DATA_WIDTH bits (two's-complement wrap).
  always_comb begin
    z_d = load_i ? acc_sum[FRAC_BITS +: DATA_WIDTH] : z_q;
  end

  assign overflow_o = 1'b0;
`endif

  // Accumulator, valid delay line and held result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      acc_q <= '0;
      z_q   <= '0;
    end else begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      z_q   <= z_d;
    end
  end

  assign z_data_o = z_q;

endmodule

// File: rtl/matrix_multiplier_v3.sv
// Signed fixed-point matrix multiplier Z = X * Y over row-major RAMs.
// Issues one X/Y read pair per cycle, drains the read pipeline, writes one
// Z element, repeats. Addresses are stepped incrementally (no multipliers).
// Optional macro MATMUL_SATURATE_EN selects clamping with an overflow flag.
// Handshake: a one-cycle start pulse is accepted only while idle; busy is
// high from the next cycle through the done cycle; done pulses once at the end.
module matrix_multiplier_v3
  import matmul_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int FRAC_BITS  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] x_rows,
  input  logic [ADDR_WIDTH-1:0] y_cols,
  input  logic [ADDR_WIDTH-1:0] x_cols_y_rows,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic [DATA_WIDTH-1:0] y_data,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  x_ren,
  output logic                  y_ren,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] z_data,
  output logic                  z_wen,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("matrix_multiplier_v3: RD_LATENCY out of range");
  end

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   m_q, m_d, n_q, n_d, kd_q, kd_d;
  logic [ADDR_WIDTH-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0]   x_addr_q, x_addr_d, y_addr_q, y_addr_d, z_addr_q, z_addr_d;
  logic                    start_clr, issue, acc_clr, load, drain_last;

  // Next-state logic and incremental address generation.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    kd_d       = kd_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    row_base_d = row_base_q;
    x_addr_d   = x_addr_q;
    y_addr_d   = y_addr_q;
    z_addr_d   = z_addr_q;
    start_clr  = 1'b0;
    issue      = 1'b0;
    acc_clr    = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_clr  = 1'b1;
          m_d        = x_rows;
          n_d        = y_cols;
          kd_d       = x_cols_y_rows;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          row_base_d = '0;
          x_addr_d   = '0;
          y_addr_d   = '0;
          z_addr_d   = '0;
          if (x_rows == '0 || y_cols == '0 || x_cols_y_rows == '0) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue    = 1'b1;
        x_addr_d = x_addr_q + ONE;
        y_addr_d = y_addr_q + n_q;
        if (k_q == kd_q - ONE) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + ONE;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          load    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        acc_clr  = 1'b1;
        z_addr_d = z_addr_q + ONE;
        if (j_q == n_q - ONE) begin
          j_d        = '0;
          i_d        = i_q + ONE;
          row_base_d = row_base_q + kd_q;
          x_addr_d   = row_base_q + kd_q;
          y_addr_d   = '0;
        end else begin
          j_d      = j_q + ONE;
          x_addr_d = row_base_q;
          y_addr_d = j_q + ONE;
        end
        if (i_q == m_q - ONE && j_q == n_q - ONE) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched dimensions, loop counters and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      n_q        <= '0;
      kd_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      row_base_q <= '0;
      x_addr_q   <= '0;
      y_addr_q   <= '0;
      z_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      kd_q       <= kd_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
      x_addr_q   <= x_addr_d;
      y_addr_q   <= y_addr_d;
      z_addr_q   <= z_addr_d;
    end
  end

  matmul_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .RD_LATENCY (RD_LATENCY)
  ) u_mac (
    .clk          (clk),
    .rst          (rst),
    .start_clr_i  (start_clr),
    .issue_i      (issue),
    .acc_clr_i    (acc_clr),
    .load_i       (load),
    .x_data_i     (x_data),
    .y_data_i     (y_data),
    .z_data_o     (z_data),
    .overflow_o   (overflow),
    .drain_last_o (drain_last)
  );

  assign x_addr = x_addr_q;
  assign y_addr = y_addr_q;
  assign z_addr = z_addr_q;
  assign x_ren  = (state_q == ISSUE);
  assign y_ren  = (state_q == ISSUE);
  assign z_wen  = (state_q == WRITE);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule
